// File: rtl/vmw_readback_if.sv
// Serial readback bus: capture request and snapshot data in, valid/ready bit stream and
// status flags out. The master drives the requests; the serializer itself is the slave.
interface vmw_readback_if #(
   parameter int unsigned WIDTH = 8
);
   logic             CAP_REQ;
   logic [WIDTH-1:0] PDATA;
   logic             SREADY;
   logic             ABORT;
   logic             OVR_CLR;
   logic             SOUT;
   logic             SVALID;
   logic             SFIRST;
   logic             SLAST;
   logic             BUSY;
   logic             DONE;
   logic             OVR;

   modport master (
      output CAP_REQ, PDATA, SREADY, ABORT, OVR_CLR,
      input  SOUT, SVALID, SFIRST, SLAST, BUSY, DONE, OVR
   );

   modport slave (
      input  CAP_REQ, PDATA, SREADY, ABORT, OVR_CLR,
      output SOUT, SVALID, SFIRST, SLAST, BUSY, DONE, OVR
   );
endinterface

// File: rtl/vmw_readback.sv
// Readback serializer: snapshots a flop bank and unloads it LSB first over a valid/ready
// stream, with an optional trailing even-parity bit and a sticky overrun flag.
module vmw_readback #(
   parameter int unsigned WIDTH  = 8,
   parameter bit          PAR_EN = 1'b0
) (
   input logic           CP,
   input logic           CLRN,
   vmw_readback_if.slave bus
);
   localparam int unsigned   CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PenIdx  = CW'(WIDTH - 2);

   typedef enum logic [1:0] {StIdle, StShift, StParity, StFin} state_e;

   state_e           r_state, w_state_d;
   // Bit 0 of the snapshot lives in r_sout, so the shadow only holds the upper bits.
   logic [WIDTH-2:0] r_shadow, w_shadow_d;
   logic [CW-1:0]    r_cnt, w_cnt_d;
   logic             r_par, w_par_d;
   logic             r_sout, w_sout_d;
   logic             r_svalid, w_svalid_d;
   logic             r_sfirst, w_sfirst_d;
   logic             r_slast, w_slast_d;
   logic             r_busy, w_busy_d;
   logic             r_done, w_done_d;
   logic             r_ovr, w_ovr_d;
   logic             w_xfer;

   always_ff @(posedge CP or negedge CLRN) begin
      if (!CLRN) begin
         r_state  <= StIdle;
         r_shadow <= '0;
         r_cnt    <= '0;
         r_par    <= 1'b0;
         r_sout   <= 1'b0;
         r_svalid <= 1'b0;
         r_sfirst <= 1'b0;
         r_slast  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_shadow <= w_shadow_d;
         r_cnt    <= w_cnt_d;
         r_par    <= w_par_d;
         r_sout   <= w_sout_d;
         r_svalid <= w_svalid_d;
         r_sfirst <= w_sfirst_d;
         r_slast  <= w_slast_d;
         r_busy   <= w_busy_d;
         r_done   <= w_done_d;
         r_ovr    <= w_ovr_d;
      end
   end

   always_comb begin
      w_state_d  = r_state;
      w_shadow_d = r_shadow;
      w_cnt_d    = r_cnt;
      w_par_d    = r_par;
      w_sout_d   = r_sout;
      w_svalid_d = r_svalid;
      w_sfirst_d = r_sfirst;
      w_slast_d  = r_slast;
      w_done_d   = 1'b0;
      w_xfer     = r_svalid & bus.SREADY;

      unique case (r_state)
         StIdle: begin
            if (bus.CAP_REQ) begin
               w_state_d  = StShift;
               w_shadow_d = bus.PDATA[WIDTH-1:1];
               w_cnt_d    = '0;
               w_par_d    = 1'b0;
               w_sout_d   = bus.PDATA[0];
               w_svalid_d = 1'b1;
               w_sfirst_d = 1'b1;
               w_slast_d  = 1'b0;
            end
         end
         StShift: begin
            if (bus.ABORT) begin
               w_state_d  = StIdle;
               w_sout_d   = 1'b0;
               w_svalid_d = 1'b0;
               w_sfirst_d = 1'b0;
               w_slast_d  = 1'b0;
            end else if (w_xfer) begin
               w_shadow_d = r_shadow >> 1;
               w_cnt_d    = r_cnt + CW'(1);
               w_par_d    = r_par ^ r_sout;
               w_sfirst_d = 1'b0;
               if (r_cnt == LastIdx) begin
                  if (PAR_EN) begin
                     w_state_d = StParity;
                     w_sout_d  = r_par ^ r_sout;
                     w_slast_d = 1'b1;
                  end else begin
                     w_state_d  = StFin;
                     w_sout_d   = 1'b0;
                     w_svalid_d = 1'b0;
                     w_slast_d  = 1'b0;
                     w_done_d   = 1'b1;
                  end
               end else begin
                  w_sout_d  = r_shadow[0];
                  w_slast_d = !PAR_EN && (r_cnt == PenIdx);
               end
            end
         end
         StParity: begin
            if (bus.ABORT) begin
               w_state_d  = StIdle;
               w_sout_d   = 1'b0;
               w_svalid_d = 1'b0;
               w_sfirst_d = 1'b0;
               w_slast_d  = 1'b0;
            end else if (w_xfer) begin
               w_state_d  = StFin;
               w_sout_d   = 1'b0;
               w_svalid_d = 1'b0;
               w_slast_d  = 1'b0;
               w_done_d   = 1'b1;
            end
         end
         StFin: begin
            w_state_d = StIdle;
         end
      endcase

      w_busy_d = (w_state_d != StIdle);

      // A rejected request outranks a simultaneous clear.
      if (bus.CAP_REQ && (r_state != StIdle)) begin
         w_ovr_d = 1'b1;
      end else if (bus.OVR_CLR) begin
         w_ovr_d = 1'b0;
      end else begin
         w_ovr_d = r_ovr;
      end
   end

   assign bus.SOUT   = r_sout;
   assign bus.SVALID = r_svalid;
   assign bus.SFIRST = r_sfirst;
   assign bus.SLAST  = r_slast;
   assign bus.BUSY   = r_busy;
   assign bus.DONE   = r_done;
   assign bus.OVR    = r_ovr;
endmodule

// File: tb/tb_vmw_readback.sv
// Bench for vmw_readback: two instances (parity off / on) share one stimulus stream and are
// scored against a frame-queue model by a negedge monitor.
module tb_vmw_readback;
   logic cp   = 1'b0;
   logic clrn = 1'b0;

   always #5 cp = ~cp;

   vmw_readback_if #(.WIDTH(8)) bus0 ();
   vmw_readback_if #(.WIDTH(8)) bus1 ();

   vmw_readback #(.WIDTH(8), .PAR_EN(1'b0)) u_dut0 (.CP(cp), .CLRN(clrn), .bus(bus0));
   vmw_readback #(.WIDTH(8), .PAR_EN(1'b1)) u_dut1 (.CP(cp), .CLRN(clrn), .bus(bus1));

   int         n_checks;
   int         n_err;
   bit         mon_en;
   bit         par_en [2] = '{1'b0, 1'b1};
   int         st [2];   // 0 idle, 1 streaming, 2 fin
   int         rem [2];
   logic       ov [2];
   logic [2:0] bq [2][$];   // {sout, sfirst, slast} per expected bit
   logic [3:0] stq [2][$];  // {svalid, busy, done, ovr} per cycle

   task automatic chk(input string name, input int d, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %b expected %b", name, d, act, exp);
      end
   endtask

   task automatic chk_zero(input int d, input logic [6:0] outs);
      n_checks++;
      if (outs !== 7'd0) begin
         n_err++;
         $display("FAIL reset_outputs dut%0d: got %b expected 0000000", d, outs);
      end
   endtask

   task automatic model_clear(input int d);
      st[d]  = 0;
      rem[d] = 0;
      ov[d]  = 1'b0;
      bq[d].delete();
      stq[d].delete();
   endtask

   task automatic model_step(input int d, input logic cap, input logic [7:0] pd,
                             input logic srdy, input logic abt, input logic clr);
      if (cap && st[d] != 0) ov[d] = 1'b1;
      else if (clr) ov[d] = 1'b0;
      case (st[d])
         0: if (cap) begin
               for (int i = 0; i < 8; i++)
                  bq[d].push_back({pd[i], i == 0, (i == 7) && !par_en[d]});
               if (par_en[d]) bq[d].push_back({^pd, 1'b0, 1'b1});
               rem[d] = par_en[d] ? 9 : 8;
               st[d]  = 1;
            end
         1: if (abt) st[d] = 0;
            else if (srdy) begin
               rem[d]--;
               if (rem[d] == 0) st[d] = 2;
            end
         default: st[d] = 0;
      endcase
      stq[d].push_back({st[d] == 1, st[d] != 0, st[d] == 2, ov[d]});
   endtask

   task automatic mon(input int d, input logic [3:0] act_st, input logic [2:0] act_bit,
                      input logic srdy, input logic abt);
      logic [3:0] e;
      logic [2:0] h;
      logic [2:0] x;
      if (!mon_en) return;
      if (stq[d].size() == 0) begin
         n_checks++;
         n_err++;
         $display("FAIL status_queue dut%0d: got empty expected one entry", d);
      end else begin
         e = stq[d].pop_front();
         chk("svalid", d, act_st[3], e[3]);
         chk("busy", d, act_st[2], e[2]);
         chk("done", d, act_st[1], e[1]);
         chk("ovr", d, act_st[0], e[0]);
      end
      if (act_st[3] === 1'b1) begin
         if (bq[d].size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL stream_queue dut%0d: got valid bit expected none", d);
         end else begin
            h = bq[d][0];
            chk("sout", d, act_bit[2], h[2]);
            chk("sfirst", d, act_bit[1], h[1]);
            chk("slast", d, act_bit[0], h[0]);
            if (abt) begin
               // Aborted frame: drop everything up to and including its last bit.
               do x = bq[d].pop_front(); while (bq[d].size() > 0 && !x[0]);
            end else if (srdy) begin
               void'(bq[d].pop_front());
            end
         end
      end
   endtask

   always @(negedge cp) begin
      mon(0, {bus0.SVALID, bus0.BUSY, bus0.DONE, bus0.OVR},
          {bus0.SOUT, bus0.SFIRST, bus0.SLAST}, bus0.SREADY, bus0.ABORT);
      mon(1, {bus1.SVALID, bus1.BUSY, bus1.DONE, bus1.OVR},
          {bus1.SOUT, bus1.SFIRST, bus1.SLAST}, bus1.SREADY, bus1.ABORT);
   end

   task automatic drive(input logic cap, input logic [7:0] pd, input logic srdy,
                        input logic abt, input logic clr);
      bus0.CAP_REQ = cap;  bus1.CAP_REQ = cap;
      bus0.PDATA   = pd;   bus1.PDATA   = pd;
      bus0.SREADY  = srdy; bus1.SREADY  = srdy;
      bus0.ABORT   = abt;  bus1.ABORT   = abt;
      bus0.OVR_CLR = clr;  bus1.OVR_CLR = clr;
      @(posedge cp);
      for (int d = 0; d < 2; d++) model_step(d, cap, pd, srdy, abt, clr);
      mon_en = 1'b1;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0);
   endtask

   task automatic check_zero_both();
      chk_zero(0, {bus0.SOUT, bus0.SVALID, bus0.SFIRST, bus0.SLAST, bus0.BUSY, bus0.DONE,
                   bus0.OVR});
      chk_zero(1, {bus1.SOUT, bus1.SVALID, bus1.SFIRST, bus1.SLAST, bus1.BUSY, bus1.DONE,
                   bus1.OVR});
   endtask

   task automatic async_reset();
      #2;
      clrn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         model_clear(d);
         stq[d].push_back(4'b0000);
      end
      #1;
      check_zero_both();
      #4;
      clrn = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      mon_en   = 1'b0;
      for (int d = 0; d < 2; d++) model_clear(d);
      bus0.CAP_REQ = 1'b0; bus0.PDATA = '0; bus0.SREADY = 1'b0;
      bus0.ABORT   = 1'b0; bus0.OVR_CLR = 1'b0;
      bus1.CAP_REQ = 1'b0; bus1.PDATA = '0; bus1.SREADY = 1'b0;
      bus1.ABORT   = 1'b0; bus1.OVR_CLR = 1'b0;
      #12;
      check_zero_both();
      #5;
      clrn = 1'b1;

      // Plain frames, then a stalled frame with bit 2 held for three extra cycles.
      drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      idle(11);
      drive(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
      idle(11);
      drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
      idle(10);

      // Rejected request in cycle 4, clear in cycle 12.
      drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      idle(3);
      drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      idle(7);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      idle(2);

      // Abort while bit 4 is presented, then a fresh 3C frame.
      drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      idle(4);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(2);
      drive(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
      idle(11);

      // Abort coinciding with the transfer of bit 7.
      drive(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
      idle(7);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(3);

      // Asynchronous reset mid-frame, then a fresh frame.
      drive(1'b1, 8'h96, 1'b1, 1'b0, 1'b0);
      idle(4);
      async_reset();
      idle(2);
      drive(1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
      idle(11);

      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
               $urandom_range(0, 29) == 0, $urandom_range(0, 15) == 0);
      end
      idle(20);

      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (bq[d].size() != 0) begin
            n_err++;
            $display("FAIL stream_drain dut%0d: got %0d bits left expected 0", d, bq[d].size());
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/vmw_readback.md
VMW_READBACK -- requirements
Module: vmw_readback

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of state bits captured and serialized (legal 2..64).
REQ-002 Parameter PAR_EN, default 0, SHALL append one even-parity bit after the data bits when 1.
REQ-003 CP  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 CLRN  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 CAP_REQ  input  1  SHALL request a capture-and-unload of PDATA.
REQ-006 PDATA  input  WIDTH  SHALL carry the parallel Q outputs of the flop bank being read back.
REQ-007 SREADY  input  1  SHALL indicate that the downstream sink accepts the current serial bit.
REQ-008 ABORT  input  1  SHALL synchronously cancel an unload in progress.
REQ-009 OVR_CLR  input  1  SHALL synchronously clear OVR.
REQ-010 SOUT  output  1  SHALL carry the current serial bit.
REQ-011 SVALID  output  1  SHALL mark SOUT as valid.
REQ-012 SFIRST / SLAST  output  1 each  SHALL mark the first and the final bit of a frame.
REQ-013 BUSY  output  1  SHALL be high in every state except IDLE.
REQ-014 DONE  output  1  SHALL pulse for one cycle when a frame completes.
REQ-015 OVR  output  1  SHALL be a sticky flag for a request that is rejected.

Function
REQ-016 States SHALL be IDLE, SHIFT, PARITY and FIN; every output SHALL be driven directly from a register.
REQ-017 In IDLE, CAP_REQ=1 at edge k SHALL load shadow<=PDATA, bit counter<=0 and parity accumulator<=0, and SHALL enter SHIFT.
REQ-018 From edge k, SVALID SHALL be 1, SOUT SHALL be PDATA[0] as captured at edge k, and SFIRST SHALL be 1 (LSB first).
REQ-019 Transfer SHALL occur only on an edge where SVALID=1 and SREADY=1; on each transfer the shadow SHALL shift right, the counter SHALL increment, and the accumulator SHALL XOR in SOUT.
REQ-020 While SREADY=0, SOUT, SVALID, SFIRST and SLAST SHALL hold their values.
REQ-021 SFIRST SHALL be 1 only while bit 0 is presented.
REQ-022 SLAST SHALL be 1 while bit WIDTH-1 is presented if PAR_EN=0, or while the parity bit is presented if PAR_EN=1.
REQ-023 On transfer of bit WIDTH-1, the next state SHALL be PARITY if PAR_EN=1; SOUT SHALL then equal the XOR of all captured bits, with SVALID=1. Otherwise the next state SHALL be FIN.
REQ-024 On transfer of the parity bit, the next state SHALL be FIN.
REQ-025 FIN SHALL last exactly one cycle with DONE=1 and SVALID=0, then return to IDLE.
REQ-026 With SREADY held at 1, the frame length from capture to FIN SHALL be WIDTH+PAR_EN cycles.
REQ-027 CAP_REQ=1 in SHIFT, PARITY or FIN SHALL be ignored for the stream and SHALL set OVR=1.
REQ-028 OVR SHALL clear on OVR_CLR=1. If OVR_CLR and a rejected CAP_REQ occur on the same edge, the set SHALL win.
REQ-029 ABORT=1 in SHIFT or PARITY SHALL force IDLE at the next edge: SVALID, SFIRST and SLAST SHALL go to 0 and no DONE SHALL be produced.
REQ-030 ABORT on the same edge as the final transfer SHALL win, so no DONE is produced.
REQ-031 ABORT in IDLE or FIN SHALL have no effect.
REQ-032 CAP_REQ and ABORT both at 1 in IDLE SHALL start a capture; ABORT SHALL be ignored.
REQ-033 PDATA SHALL be sampled only at the capture edge; later changes to PDATA SHALL not alter the frame.

Reset
REQ-034 CLRN=0 SHALL immediately force IDLE and set SOUT, SVALID, SFIRST, SLAST, BUSY, DONE and OVR to 0; the shadow, counter and accumulator SHALL reset to 0.
REQ-035 CLRN=0 during a frame SHALL discard the frame with no DONE; the first CAP_REQ after CLRN returns to 1 SHALL start a fresh frame.

Verification
REQ-036 WIDTH=8, PAR_EN=0, PDATA=8'hA5, SREADY=1 -> SOUT sequence SHALL be 1,0,1,0,0,1,0,1 over cycles 1-8; SFIRST SHALL be high in cycle 1, SLAST in cycle 8, DONE in cycle 9; BUSY SHALL be high in cycles 1-9.
REQ-037 PAR_EN=1, PDATA=8'hA5 then 8'h07 -> the ninth bit SHALL be 0 then 1, with SLAST on the ninth bit and DONE in cycle 10.
REQ-038 8'hA5 with SREADY=0 for 3 cycles while bit 2 is presented -> SOUT SHALL hold 1 with SVALID=1 for 4 cycles; the rest of the sequence SHALL be unchanged and DONE SHALL occur in cycle 12.
REQ-039 CAP_REQ pulse in cycle 4 of a frame -> OVR SHALL be 1 from cycle 5 and the stream SHALL be unaffected; OVR_CLR in cycle 12 -> OVR SHALL be 0 in cycle 13.
REQ-040 ABORT while bit 4 is presented -> SVALID=0 and BUSY=0 on the next cycle and DONE never asserts; a new CAP_REQ with PDATA=8'h3C SHALL produce 0,0,1,1,1,1,0,0.
REQ-041 CLRN pulsed low mid-frame (asynchronously, between CP edges) -> all outputs SHALL be 0 before the next CP edge and no DONE SHALL follow.
